// File: rtl/mux13_rr_arbiter.sv
// mux13_rr_arbiter
//   Round-robin arbiter that time-shares one 13:1 mux among 13 requesters.
//   A grant is held until the owner drops its request or the hold timer
//   expires. Between owners the arbiter passes through a GAP cycle and then
//   an IDLE cycle, so the mux select never switches while data is valid.
//   All outputs are registered.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        [N]      request per mux input
//   gnt        [N]      one-hot grant, zero when nobody owns the mux
//   select     [SEL_W]  mux select, holds the last owner between grants
//   sel_valid  1 while a grant is active
//   timeout    one-cycle pulse when a grant was revoked by the hold timer
//   owner      [SEL_W]  current/last owner index (same value as select)
module mux13_rr_arbiter #(
    parameter int N           = 13,
    parameter int SEL_W       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] select,
    output logic             sel_valid,
    output logic             timeout,
    output logic [SEL_W-1:0] owner
);

    localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N-1:0]     gnt_n;
    logic [SEL_W-1:0] select_n;
    logic             valid_n;
    logic             timeout_n;

    // Round-robin search starting at ptr. cand carries one extra bit so
    // ptr+i cannot overflow before the wrap back into 0..N-1.
    logic [SEL_W:0]   cand;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    always_comb begin
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(N))
                cand = cand - (SEL_W+1)'(N);
            if (!pick_found && req[cand[SEL_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Pointer value that makes the owner the last candidate next round.
    logic [SEL_W-1:0] ptr_after_owner;
    assign ptr_after_owner = (select == SEL_W'(N-1)) ? '0 : select + 1'b1;

    logic cnt_at_limit;
    assign cnt_at_limit = (HOLD_CYCLES != 0) && (cnt == CNT_W'(HOLD_CYCLES));

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt;
        select_n  = select;
        valid_n   = sel_valid;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n   = '0;
                valid_n = 1'b0;
                if (pick_found) begin
                    state_n  = GRANT;
                    gnt_n    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    select_n = pick_idx;
                    valid_n  = 1'b1;
                    cnt_n    = CNT_W'(1);
                end
            end
            GRANT: begin
                // Release is checked first so it beats a simultaneous timeout.
                if (!req[select]) begin
                    state_n = GAP;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    ptr_n   = ptr_after_owner;
                end else if (cnt_at_limit) begin
                    state_n   = GAP;
                    gnt_n     = '0;
                    valid_n   = 1'b0;
                    timeout_n = 1'b1;
                    ptr_n     = ptr_after_owner;
                end else if (HOLD_CYCLES != 0 && cnt < CNT_W'(HOLD_CYCLES)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
                gnt_n   = '0;
                valid_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            select    <= '0;
            sel_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            select    <= select_n;
            sel_valid <= valid_n;
            timeout   <= timeout_n;
        end
    end

    assign owner = select;

endmodule

// File: tb/tb_mux13_rr_arbiter.sv
// Directed bench for mux13_rr_arbiter with HOLD_CYCLES=4. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_mux13_rr_arbiter;

    localparam int N     = 13;
    localparam int SEL_W = 4;
    localparam int HOLD  = 4;
    localparam int OW    = N + 2*SEL_W + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] select;
    logic             sel_valid;
    logic             timeout;
    logic [SEL_W-1:0] owner;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux13_rr_arbiter #(.N(N), .SEL_W(SEL_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .select(select),
        .sel_valid(sel_valid), .timeout(timeout), .owner(owner)
    );

    // Bench-side model of the downstream mux: input k carries 1 only when
    // k equals the current select.
    logic [N-1:0] din;
    logic         y;
    always_comb begin
        for (int k = 0; k < N; k++) din[k] = (k == int'(select));
        y = (int'(select) < N) ? din[select] : 1'b0;
    end

    wire [OW-1:0] obs = {gnt, select, owner, sel_valid, timeout};

    function automatic logic [N-1:0] oh(input int k);
        oh = {{(N-1){1'b0}}, 1'b1} << k;
    endfunction

    function automatic logic [OW-1:0] pack(input logic [N-1:0] g, input int s,
                                           input logic v, input logic t);
        pack = {g, SEL_W'(s), SEL_W'(s), v, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        step();
        step();
        tests++;
        if (obs !== pack('0, 0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", obs, pack('0, 0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        step();
        tests++;
        if (obs !== pack(oh(0), 0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL first_grant: got %h want %h", obs, pack(oh(0), 0, 1'b1, 1'b0));
        end
    endtask

    // All requesters held: each owner gets HOLD cycles, then a GAP cycle
    // with the timeout pulse, then an IDLE cycle; 12 wraps back to 0.
    task automatic test_round_robin();
        for (int r = 0; r < 14; r++) begin
            int k;
            k = r % N;
            for (int c = 0; c < HOLD; c++) begin
                tests++;
                if (obs !== pack(oh(k), k, 1'b1, 1'b0)) begin
                    fails++;
                    $display("FAIL rr_grant k=%0d c=%0d: got %h want %h", k, c, obs,
                             pack(oh(k), k, 1'b1, 1'b0));
                end
                step();
            end
            tests++;
            if (obs !== pack('0, k, 1'b0, 1'b1)) begin
                fails++;
                $display("FAIL rr_timeout_gap k=%0d: got %h want %h", k, obs,
                         pack('0, k, 1'b0, 1'b1));
            end
            if (r == 13) req = '0;
            step();
            tests++;
            if (obs !== pack('0, k, 1'b0, 1'b0)) begin
                fails++;
                $display("FAIL rr_idle k=%0d: got %h want %h", k, obs, pack('0, k, 1'b0, 1'b0));
            end
            step();
        end
    endtask

    // Lone requester 5 held three cycles then dropped; no timeout.
    task automatic test_single_release();
        req = oh(5);
        step();
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (obs !== pack(oh(5), 5, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL single_grant c=%0d: got %h want %h", c, obs,
                         pack(oh(5), 5, 1'b1, 1'b0));
            end
            if (c == 2) req = '0;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (obs !== pack('0, 5, 1'b0, 1'b0)) begin
                fails++;
                $display("FAIL single_gap_idle c=%0d: got %h want %h", c, obs,
                         pack('0, 5, 1'b0, 1'b0));
            end
            step();
        end
    endtask

    // Owner 3 releases on the very cycle its counter reaches HOLD.
    task automatic test_release_at_limit();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        req = oh(3) | oh(9);
        step();
        for (int c = 0; c < HOLD; c++) begin
            tests++;
            if (obs !== pack(oh(3), 3, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL limit_grant3 c=%0d: got %h want %h", c, obs,
                         pack(oh(3), 3, 1'b1, 1'b0));
            end
            if (c == HOLD-1) req = oh(9);
            step();
        end
        tests++;
        if (obs !== pack('0, 3, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL release_wins: got %h want %h", obs, pack('0, 3, 1'b0, 1'b0));
        end
        step();
        step();
        tests++;
        if (obs !== pack(oh(9), 9, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL next_grant9: got %h want %h", obs, pack(oh(9), 9, 1'b1, 1'b0));
        end
        req = '0;
        step();
        step();
    endtask

    // Reset while 7 owns the mux: pointer returns to 0, so 2 beats 7.
    task automatic test_reset_mid_grant();
        req = oh(7);
        step();
        step();
        tests++;
        if (obs !== pack(oh(7), 7, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL grant7: got %h want %h", obs, pack(oh(7), 7, 1'b1, 1'b0));
        end
        rst = 1'b1;
        req = oh(7) | oh(2);
        step();
        tests++;
        if (obs !== pack('0, 0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL mid_reset: got %h want %h", obs, pack('0, 0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        step();
        tests++;
        if (obs !== pack(oh(2), 2, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL post_reset_ptr0: got %h want %h", obs, pack(oh(2), 2, 1'b1, 1'b0));
        end
        req = '0;
        step();
        step();
    endtask

    // Random request bursts; every cycle check the mux output and the
    // grant/select invariants.
    task automatic test_mux_onehot();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic ok;
            if (cyc % 7 == 0) req = N'($urandom) & N'($urandom);
            ok = $onehot0(gnt) && ((gnt != '0) == sel_valid) && (int'(select) < N)
                 && (owner == select) && !(timeout && sel_valid);
            if (sel_valid) ok = ok && (y == 1'b1) && (gnt == oh(int'(select)));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL mux_onehot cyc=%0d: got gnt=%h sel=%0d own=%0d v=%b t=%b y=%b want onehot-consistent y=1",
                         cyc, gnt, select, owner, sel_valid, timeout, y);
            end
            step();
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_release();
        test_release_at_limit();
        test_reset_mid_grant();
        test_mux_onehot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
